// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall/flush/req and perf counters
module pipe_stage_reg #(
  parameter int          DATA_W           = 32,
  parameter int          PC_OFFSET        = 0,
  parameter logic [31:0] RESET_PC         = 32'h0000_3000,
  parameter logic [31:0] REQ_PC           = 32'h0000_4180,
  parameter int          EXC_W            = 5,
  parameter int          CNT_W            = 16,
  parameter bit          KEEP_PC_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              req,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_instr,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_valid,
  input  logic [EXC_W-1:0]  d_exc_in,
  input  logic [EXC_W-1:0]  d_exc_new,
  input  logic              d_bd,
  output logic [31:0]       q_pc,
  output logic [31:0]       q_instr,
  output logic [DATA_W-1:0] q_data,
  output logic              q_valid,
  output logic [EXC_W-1:0]  q_exc,
  output logic              q_bd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [31:0]      PC_ADD  = 32'(PC_OFFSET);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      next_pc;
  logic [EXC_W-1:0] merged_exc;
  logic             stall_evt;
  logic             bubble_evt;

  assign next_pc = d_pc + PC_ADD;

  // Oldest exception wins; an upstream bubble can never carry one.
  assign merged_exc = !d_valid              ? '0 :
                      (d_exc_in != '0)      ? d_exc_in : d_exc_new;

  assign stall_evt  = !reset && !req && stall;
  assign bubble_evt = !reset && !req && !stall && (flush || !d_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_pc    <= RESET_PC;
      q_instr <= '0;
      q_data  <= '0;
      q_valid <= 1'b0;
      q_exc   <= '0;
      q_bd    <= 1'b0;
    end else if (req) begin
      q_pc    <= REQ_PC;
      q_instr <= '0;
      q_data  <= '0;
      q_valid <= 1'b0;
      q_exc   <= '0;
      q_bd    <= 1'b0;
    end else if (stall) begin
      q_pc    <= q_pc;
      q_instr <= q_instr;
      q_data  <= q_data;
      q_valid <= q_valid;
      q_exc   <= q_exc;
      q_bd    <= q_bd;
    end else if (flush) begin
      // Retaining PC/bd on a bubble lets the exception unit report a precise EPC.
      q_pc    <= KEEP_PC_ON_FLUSH ? next_pc : 32'h0;
      q_bd    <= KEEP_PC_ON_FLUSH ? d_bd    : 1'b0;
      q_instr <= '0;
      q_data  <= '0;
      q_valid <= 1'b0;
      q_exc   <= '0;
    end else begin
      q_pc    <= next_pc;
      q_instr <= d_instr;
      q_data  <= d_data;
      q_valid <= d_valid;
      q_exc   <= merged_exc;
      q_bd    <= d_bd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (bubble_evt && (bubble_cnt != CNT_MAX))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
